// File: rtl/uart_tx_fifo_if.sv
// Valid/ready word handshake between a producer and uart_tx_fifo.
interface uart_tx_fifo_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] dataIn;
    logic             dataValid;
    logic             dataReady;

    modport master (output dataIn, output dataValid, input dataReady);
    modport slave  (input dataIn, input dataValid, output dataReady);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO in front of a configurable-format serialiser.
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned BREAK_BITS = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    uart_tx_fifo_if.slave               bus,
    input  logic [1:0]                  parityMode,
    input  logic                        twoStop,
`ifdef UART_TX_BREAK_EN
    input  logic                        sendBreak,
`endif
    output logic                        uartTx,
    output logic                        txBusy,
    output logic                        txDone,
    output logic [$clog2(FIFO_DEPTH):0] fifoCount
);
    localparam int unsigned BAUD_COUNT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned BAUD_W     = $clog2(BAUD_COUNT);
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;
    localparam int unsigned BIT_MAX    = (WIDTH > BREAK_BITS) ? WIDTH : BREAK_BITS;
    localparam int unsigned BIT_W      = $clog2(BIT_MAX);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, DONE
`ifdef UART_TX_BREAK_EN
        , BREAK
`endif
    } state_t;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ready, push, pop;

    state_t           state, state_nxt;
    logic [BAUD_W-1:0] baud, baud_nxt;
    logic [BIT_W-1:0] bit_cnt, bit_nxt;
    logic [WIDTH-1:0] shreg, sh_nxt;
    logic             par_bit, par_nxt, par_en, par_en_nxt;
    logic             two, two_nxt, brk, brk_nxt, tx, tx_nxt;
    logic             busy, done, bit_end;

    assign bus.dataReady = ready;
    assign uartTx        = tx;
    assign txBusy        = busy;
    assign txDone        = done;
    assign fifoCount     = cnt;

    assign push    = bus.dataValid && ready;
    assign cnt_nxt = cnt + CNT_W'(push) - CNT_W'(pop);
    assign bit_end = (baud == BAUD_W'(BAUD_COUNT - 1));

    // FIFO storage; ready is registered so a pop never combinationally frees a slot
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.dataIn;
    end

    always_comb begin
        state_nxt  = state;
        baud_nxt   = (state == IDLE || state == DONE) ? '0 : baud + BAUD_W'(1);
        bit_nxt    = bit_cnt;
        sh_nxt     = shreg;
        par_nxt    = par_bit;
        par_en_nxt = par_en;
        two_nxt    = two;
        brk_nxt    = brk;
        tx_nxt     = tx;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                brk_nxt = 1'b0;
`ifdef UART_TX_BREAK_EN
                if (sendBreak) begin
                    state_nxt = BREAK;
                    tx_nxt    = 1'b0;
                    bit_nxt   = '0;
                end else
`endif
                if (cnt != '0) begin
                    pop        = 1'b1;
                    sh_nxt     = mem[rd_ptr];
                    par_en_nxt = (parityMode == 2'b01) || (parityMode == 2'b10);
                    par_nxt    = (^mem[rd_ptr]) ^ (parityMode == 2'b10);
                    two_nxt    = twoStop;
                    state_nxt  = START;
                    tx_nxt     = 1'b0;
                end
            end
            START: if (bit_end) begin
                state_nxt = DATA;
                baud_nxt  = '0;
                bit_nxt   = '0;
                tx_nxt    = shreg[0];
            end
            DATA: if (bit_end) begin
                baud_nxt = '0;
                if (bit_cnt == BIT_W'(WIDTH - 1)) begin
                    bit_nxt   = '0;
                    state_nxt = par_en ? PARITY : STOP;
                    tx_nxt    = par_en ? par_bit : 1'b1;
                end else begin
                    bit_nxt = bit_cnt + BIT_W'(1);
                    sh_nxt  = shreg >> 1;
                    tx_nxt  = shreg[1];
                end
            end
            PARITY: if (bit_end) begin
                state_nxt = STOP;
                baud_nxt  = '0;
                bit_nxt   = '0;
                tx_nxt    = 1'b1;
            end
            // second stop bit reuses bit_cnt as a flag
            STOP: if (bit_end) begin
                baud_nxt = '0;
                if (two && bit_cnt == '0) bit_nxt = BIT_W'(1);
                else state_nxt = brk ? IDLE : DONE;
            end
            DONE: state_nxt = IDLE;
`ifdef UART_TX_BREAK_EN
            BREAK: if (bit_end) begin
                baud_nxt = '0;
                if (bit_cnt == BIT_W'(BREAK_BITS - 1)) begin
                    state_nxt = STOP;
                    bit_nxt   = '0;
                    two_nxt   = 1'b0;
                    brk_nxt   = 1'b1;
                    tx_nxt    = 1'b1;
                end else begin
                    bit_nxt = bit_cnt + BIT_W'(1);
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            par_en  <= 1'b0;
            two     <= 1'b0;
            brk     <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            ready   <= 1'b1;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            state   <= state_nxt;
            baud    <= baud_nxt;
            bit_cnt <= bit_nxt;
            shreg   <= sh_nxt;
            par_bit <= par_nxt;
            par_en  <= par_en_nxt;
            two     <= two_nxt;
            brk     <= brk_nxt;
            tx      <= tx_nxt;
            busy    <= (state_nxt != IDLE);
            done    <= (state_nxt == DONE);
            cnt     <= cnt_nxt;
            ready   <= (cnt_nxt != CNT_W'(FIFO_DEPTH));
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (10 clocks per bit, 8 data bits, 4-deep FIFO).
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] parityMode;
    logic       twoStop;
    logic       uartTx, txBusy, txDone;
    logic [2:0] fifoCount;
`ifdef UART_TX_BREAK_EN
    logic       sendBreak;
`endif
    int checks   = 0;
    int failures = 0;
    logic [7:0] fill_words [6];

    uart_tx_fifo_if #(.WIDTH(8)) bus ();

    uart_tx_fifo #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .WIDTH(8),
        .FIFO_DEPTH(4), .BREAK_BITS(12)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .parityMode(parityMode), .twoStop(twoStop),
`ifdef UART_TX_BREAK_EN
        .sendBreak(sendBreak),
`endif
        .uartTx(uartTx), .txBusy(txBusy), .txDone(txDone), .fifoCount(fifoCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Hold valid until accepted; returns 1ns after the accepting edge
    task automatic push_word(input logic [7:0] d);
        int n;
        n = 0;
        bus.dataIn    = d;
        bus.dataValid = 1'b1;
        while (!bus.dataReady && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", 32'(bus.dataReady), 32'd1);
        @(posedge clk);
        #1;
        bus.dataValid = 1'b0;
    endtask

    // expv bit j is the j-th bit on the line (start first)
    task automatic tx_frame(input string tag, input logic [7:0] d, input logic [1:0] pm,
                            input logic two, input logic [11:0] expv, input int len,
                            input logic flip);
        int done_cnt;
        int done_k;
        done_cnt   = 0;
        done_k     = 2 + len * 10;
        parityMode = pm;
        twoStop    = two;
        @(negedge clk);
        push_word(d);
        for (int k = 1; k <= done_k + 2; k++) begin
            @(negedge clk);
            if (flip && k == 20) begin
                parityMode = 2'b00;
                twoStop    = 1'b0;
            end
            if (txDone) done_cnt++;
            if (k == 2) check({tag, "_busy"}, 32'(txBusy), 32'd1);
            if (k >= 2 && (k - 2) % 10 == 5 && (k - 2) / 10 < len)
                check($sformatf("%s_bit%0d", tag, (k - 2) / 10), 32'(uartTx),
                      32'(expv[(k - 2) / 10]));
            if (k == done_k) check({tag, "_done"}, 32'(txDone), 32'd1);
        end
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_idle"}, 32'(txBusy), 32'd0);
    endtask

    // Decode n frames from the line, checking data order and inter-frame spacing
    task automatic rx_frames(input int n);
        int k;
        int last_k;
        k      = 0;
        last_k = 0;
        for (int f = 0; f < n; f++) begin
            int w;
            logic [7:0] d;
            w = 0;
            d = '0;
            while (uartTx !== 1'b0 && w < 400) begin
                @(negedge clk);
                k++;
                w++;
            end
            check("rx_start", 32'(uartTx), 32'd0);
            if (f > 0) check("rx_gap", 32'(k - last_k), 32'd102);
            last_k = k;
            repeat (5) @(negedge clk);
            k += 5;
            for (int j = 1; j <= 9; j++) begin
                repeat (10) @(negedge clk);
                k += 10;
                if (j <= 8) d[j - 1] = uartTx;
                else check("rx_stop", 32'(uartTx), 32'd1);
            end
            check($sformatf("rx_data%0d", f), 32'(d), 32'(fill_words[f]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        fill_words = '{8'h11, 8'h82, 8'h3C, 8'hF0, 8'h5A, 8'hC7};
        reset         = 1'b1;
        parityMode    = 2'b00;
        twoStop       = 1'b0;
        bus.dataIn    = '0;
        bus.dataValid = 1'b0;
`ifdef UART_TX_BREAK_EN
        sendBreak     = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(uartTx), 32'd1);
        check("rst_busy", 32'(txBusy), 32'd0);
        check("rst_done", 32'(txDone), 32'd0);
        check("rst_ready", 32'(bus.dataReady), 32'd1);
        check("rst_count", 32'(fifoCount), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_tx", 32'(uartTx), 32'd1);

        tx_frame("a5",     8'hA5, 2'b00, 1'b0, 12'h34A, 10, 1'b0);
        tx_frame("even",   8'h07, 2'b01, 1'b0, 12'h60E, 11, 1'b0);
        tx_frame("odd",    8'h07, 2'b10, 1'b0, 12'h40E, 11, 1'b0);
        tx_frame("odd2",   8'h07, 2'b10, 1'b1, 12'hC0E, 12, 1'b1);
        tx_frame("mode11", 8'h07, 2'b11, 1'b0, 12'h20E, 10, 1'b0);

        // Fill the FIFO behind an active frame, then push into a full FIFO across a pop
        parityMode = 2'b00;
        twoStop    = 1'b0;
        fork
            begin
                @(negedge clk);
                for (int i = 0; i < 5; i++) push_word(fill_words[i]);
                @(negedge clk);
                check("fill_count", 32'(fifoCount), 32'd4);
                check("fill_ready", 32'(bus.dataReady), 32'd0);
                bus.dataIn    = fill_words[5];
                bus.dataValid = 1'b1;
                n = 0;
                while (fifoCount == 3'd4 && n < 300) begin
                    @(negedge clk);
                    n++;
                end
                check("full_pop_count", 32'(fifoCount), 32'd3);
                check("full_pop_ready", 32'(bus.dataReady), 32'd1);
                @(posedge clk);
                #1;
                bus.dataValid = 1'b0;
                @(negedge clk);
                check("refill_count", 32'(fifoCount), 32'd4);
            end
            rx_frames(6);
        join
        repeat (150) @(negedge clk);
        check("drain_tx", 32'(uartTx), 32'd1);
        check("drain_count", 32'(fifoCount), 32'd0);
        check("drain_busy", 32'(txBusy), 32'd0);

        // Asynchronous reset in the middle of data bit 3 with words still buffered
        @(negedge clk);
        push_word(8'hC3);
        push_word(8'h99);
        push_word(8'h66);
        repeat (45) @(negedge clk);
        check("mid_bit3_tx", 32'(uartTx), 32'd0);
        check("mid_count", 32'(fifoCount), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("arst_tx", 32'(uartTx), 32'd1);
        check("arst_busy", 32'(txBusy), 32'd0);
        check("arst_count", 32'(fifoCount), 32'd0);
        check("arst_ready", 32'(bus.dataReady), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("arst_hold_count", 32'(fifoCount), 32'd0);
        tx_frame("post_rst", 8'h3C, 2'b00, 1'b0, 12'h278, 10, 1'b0);

`ifdef UART_TX_BREAK_EN
        begin
            int dcnt;
            logic [9:0] exp55;
            dcnt  = 0;
            exp55 = 10'b1010101010;
            @(negedge clk);
            sendBreak     = 1'b1;
            bus.dataIn    = 8'h55;
            bus.dataValid = 1'b1;
            @(posedge clk);
            #1;
            sendBreak     = 1'b0;
            bus.dataValid = 1'b0;
            for (int k = 1; k <= 240; k++) begin
                @(negedge clk);
                if (txDone) dcnt++;
                if (k == 1 || k == 60 || k == 120) check("brk_low", 32'(uartTx), 32'd0);
                if (k == 60) check("brk_fifo_held", 32'(fifoCount), 32'd1);
                if (k == 100) check("brk_busy", 32'(txBusy), 32'd1);
                if (k == 121 || k == 131) check("brk_stop_high", 32'(uartTx), 32'd1);
                if (k == 131) check("brk_no_done", 32'(dcnt), 32'd0);
                if (k >= 132 && (k - 132) % 10 == 5 && (k - 132) / 10 < 10)
                    check($sformatf("brk55_bit%0d", (k - 132) / 10), 32'(uartTx),
                          32'(exp55[(k - 132) / 10]));
                if (k == 232) check("brk55_done", 32'(txDone), 32'd1);
            end
            check("brk_done_count", 32'(dcnt), 32'd1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
